// File: rtl/flex_pkg.sv
// Shared definitions for the flex primary bus blocks: arbiter FSM states and
// the round-robin wrap helper.
`ifndef BB_ADDR_BUS_WIDTH
`define BB_ADDR_BUS_WIDTH 16
`endif
`ifndef BB_DATA_BUS_WIDTH
`define BB_DATA_BUS_WIDTH 16
`endif

package flex_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_HOLD    = 2'd2,
    ST_RELEASE = 2'd3
  } flex_state_e;

  // Next requester index after idx, wrapping at n.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/flex_rr_select.sv
// Combinational round-robin pick: first requester found searching upward from
// last+1 with wrap. valid is low when no request is present.
module flex_rr_select
  import flex_pkg::*;
#(
  parameter int N  = 2,
  parameter int GW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [GW-1:0] last,
  output logic [GW-1:0] idx,
  output logic          valid
);

  always_comb begin
    logic [GW-1:0] cand;
    idx   = '0;
    valid = 1'b0;
    cand  = GW'(rr_next(int'(last), N));
    for (int k = 0; k < N; k++) begin
      if (!valid && req[cand]) begin
        idx   = cand;
        valid = 1'b1;
      end
      cand = GW'(rr_next(int'(cand), N));
    end
  end

endmodule

// File: rtl/flex_arbiter.sv
// Round-robin arbiter sharing one flex primary bus among nr_masters requesters,
// holding each transfer until its owner releases it and timing out unmapped accesses.
module flex_arbiter
  import flex_pkg::*;
#(
  parameter int addr_bus_width = `BB_ADDR_BUS_WIDTH,
  parameter int data_bus_width = `BB_DATA_BUS_WIDTH,
  parameter int nr_masters     = 2,
  parameter int timeout_cycles = 255,
  localparam int GW = (nr_masters > 1) ? $clog2(nr_masters) : 1,
  localparam int CW = $clog2(timeout_cycles + 1)
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic [nr_masters*addr_bus_width-1:0] m_addr,
  input  logic [nr_masters*data_bus_width-1:0] m_data_w,
  input  logic [nr_masters-1:0]                m_addr_strobe,
  input  logic [nr_masters-1:0]                m_read_trg,
  input  logic [nr_masters-1:0]                m_write_trg,
  output logic [nr_masters-1:0]                m_dtack,
  output logic [nr_masters-1:0]                m_data_r_act,
  output logic [nr_masters-1:0]                m_timeout,
  output logic [data_bus_width-1:0]            m_data_r,
  output logic [addr_bus_width-1:0]            addr,
  output logic [data_bus_width-1:0]            data_w,
  output logic                                 addr_strobe,
  output logic                                 read_trg,
  output logic                                 write_trg,
  input  logic [data_bus_width-1:0]            data_r,
  input  logic                                 data_r_act,
  input  logic                                 dtack,
  output logic [GW-1:0]                        grant
);

  flex_state_e                 state_q, state_d;
  logic [GW-1:0]               grant_q, grant_d;
  logic [addr_bus_width-1:0]   addr_q, addr_d;
  logic [data_bus_width-1:0]   data_w_q, data_w_d;
  logic                        is_rd_q, is_rd_d;
  logic                        strobe_q, strobe_d;
  logic                        rd_trg_q, rd_trg_d;
  logic                        wr_trg_q, wr_trg_d;
  logic [CW-1:0]               cnt_q, cnt_d;
  logic [nr_masters-1:0]       m_dtack_q, m_dtack_d;
  logic [nr_masters-1:0]       m_act_q, m_act_d;
  logic [nr_masters-1:0]       m_to_q, m_to_d;
  logic [data_bus_width-1:0]   m_data_r_q, m_data_r_d;

  logic [nr_masters-1:0] req;
  logic [nr_masters-1:0] g_onehot;
  logic                  g_req;
  logic [GW-1:0]         sel_idx;
  logic                  sel_vld;

  assign req      = m_addr_strobe & (m_read_trg | m_write_trg);
  assign g_req    = req[grant_q];
  assign g_onehot = {{(nr_masters-1){1'b0}}, 1'b1} << grant_q;

  flex_rr_select #(.N(nr_masters), .GW(GW)) u_rr_select (
    .req   (req),
    .last  (grant_q),
    .idx   (sel_idx),
    .valid (sel_vld)
  );

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    addr_d     = addr_q;
    data_w_d   = data_w_q;
    is_rd_d    = is_rd_q;
    strobe_d   = strobe_q;
    rd_trg_d   = rd_trg_q;
    wr_trg_d   = wr_trg_q;
    cnt_d      = cnt_q;
    m_dtack_d  = m_dtack_q;
    m_act_d    = m_act_q;
    m_to_d     = m_to_q;
    m_data_r_d = m_data_r_q;
    case (state_q)
      ST_IDLE: begin
        strobe_d = 1'b0;
        rd_trg_d = 1'b0;
        wr_trg_d = 1'b0;
        if (sel_vld) begin
          grant_d  = sel_idx;
          addr_d   = m_addr[int'(sel_idx)*addr_bus_width +: addr_bus_width];
          data_w_d = m_data_w[int'(sel_idx)*data_bus_width +: data_bus_width];
          is_rd_d  = m_read_trg[sel_idx];
          cnt_d    = '0;
          state_d  = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        strobe_d = 1'b1;
        rd_trg_d = is_rd_q;
        wr_trg_d = !is_rd_q;
        // A master that walks away mid-access is never acknowledged.
        if (!g_req) begin
          strobe_d = 1'b0;
          rd_trg_d = 1'b0;
          wr_trg_d = 1'b0;
          state_d  = ST_RELEASE;
        end else if (dtack) begin
          m_data_r_d = data_r;
          m_act_d    = data_r_act ? g_onehot : '0;
          m_dtack_d  = g_onehot;
          state_d    = ST_HOLD;
        end else if (cnt_q == CW'(timeout_cycles - 1)) begin
          m_dtack_d = g_onehot;
          m_to_d    = g_onehot;
          strobe_d  = 1'b0;
          rd_trg_d  = 1'b0;
          wr_trg_d  = 1'b0;
          state_d   = ST_HOLD;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_HOLD: begin
        if (!g_req) begin
          m_dtack_d = '0;
          m_act_d   = '0;
          m_to_d    = '0;
          strobe_d  = 1'b0;
          rd_trg_d  = 1'b0;
          wr_trg_d  = 1'b0;
          state_d   = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (!dtack) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      grant_q    <= GW'(nr_masters - 1);
      addr_q     <= '0;
      data_w_q   <= '0;
      is_rd_q    <= 1'b0;
      strobe_q   <= 1'b0;
      rd_trg_q   <= 1'b0;
      wr_trg_q   <= 1'b0;
      cnt_q      <= '0;
      m_dtack_q  <= '0;
      m_act_q    <= '0;
      m_to_q     <= '0;
      m_data_r_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      addr_q     <= addr_d;
      data_w_q   <= data_w_d;
      is_rd_q    <= is_rd_d;
      strobe_q   <= strobe_d;
      rd_trg_q   <= rd_trg_d;
      wr_trg_q   <= wr_trg_d;
      cnt_q      <= cnt_d;
      m_dtack_q  <= m_dtack_d;
      m_act_q    <= m_act_d;
      m_to_q     <= m_to_d;
      m_data_r_q <= m_data_r_d;
    end
  end

  assign m_dtack      = m_dtack_q;
  assign m_data_r_act = m_act_q;
  assign m_timeout    = m_to_q;
  assign m_data_r     = m_data_r_q;
  assign addr         = addr_q;
  assign data_w       = data_w_q;
  assign addr_strobe  = strobe_q;
  assign read_trg     = rd_trg_q;
  assign write_trg    = wr_trg_q;
  assign grant        = grant_q;

endmodule

// File: tb/tb_flex_arbiter.sv
// Bench for flex_arbiter: behavioural register-bank slave plus a transaction-level
// model (round-robin order, register contents, latency, timeout) for checking.
module tb_flex_arbiter;
  localparam int NM = 3;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int T  = 8;
  localparam int GW = 2;

  logic              clock, reset;
  logic [NM*AW-1:0]  m_addr;
  logic [NM*DW-1:0]  m_data_w;
  logic [NM-1:0]     m_addr_strobe, m_read_trg, m_write_trg;
  logic [NM-1:0]     m_dtack, m_data_r_act, m_timeout;
  logic [DW-1:0]     m_data_r;
  logic [AW-1:0]     addr;
  logic [DW-1:0]     data_w;
  logic              addr_strobe, read_trg, write_trg;
  logic [DW-1:0]     data_r;
  logic              data_r_act, dtack;
  logic [GW-1:0]     grant;

  flex_arbiter #(.addr_bus_width(AW), .data_bus_width(DW), .nr_masters(NM),
                 .timeout_cycles(T)) dut (
    .clock(clock), .reset(reset), .m_addr(m_addr), .m_data_w(m_data_w),
    .m_addr_strobe(m_addr_strobe), .m_read_trg(m_read_trg), .m_write_trg(m_write_trg),
    .m_dtack(m_dtack), .m_data_r_act(m_data_r_act), .m_timeout(m_timeout),
    .m_data_r(m_data_r), .addr(addr), .data_w(data_w), .addr_strobe(addr_strobe),
    .read_trg(read_trg), .write_trg(write_trg), .data_r(data_r),
    .data_r_act(data_r_act), .dtack(dtack), .grant(grant));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Slave: registers at 0x0000..0x00FF, acks sl_lat cycles after seeing a trigger.
  int            sl_lat = 0;
  int            sl_cnt = 0;
  logic          dtack_force = 1'b0;
  logic [DW-1:0] sl_mem [0:255] = '{default: '0};
  logic          sl_act, sl_ack;
  assign sl_act     = addr_strobe & (read_trg | write_trg) & (addr[AW-1:8] == '0);
  assign sl_ack     = sl_act & (sl_cnt >= sl_lat);
  assign dtack      = sl_ack | dtack_force;
  assign data_r     = (sl_ack & read_trg) ? sl_mem[addr[7:0]] : '0;
  assign data_r_act = sl_ack & read_trg;
  always @(posedge clock) begin
    if (sl_act) sl_cnt <= sl_cnt + 1;
    else        sl_cnt <= 0;
    if (sl_ack & write_trg) sl_mem[addr[7:0]] <= data_w;
  end

  int errors = 0;
  int checks = 0;
  logic [DW-1:0] ref_mem [0:255] = '{default: '0};
  int            model_last = NM - 1;
  logic [DW-1:0] last_data = '0;
  logic [AW-1:0] op_addr [NM];
  logic [DW-1:0] op_data [NM];
  bit            op_rd   [NM];
  bit            op_both [NM];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_pick(input logic [NM-1:0] m, input int last);
    for (int k = 1; k <= NM; k++) if (m[(last + k) % NM]) return (last + k) % NM;
    return -1;
  endfunction

  function automatic bit mapped(input logic [AW-1:0] a);
    return a[AW-1:8] == '0;
  endfunction

  task automatic set_op(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input bit rd, input bit both);
    op_addr[i] = a; op_data[i] = d; op_rd[i] = rd; op_both[i] = both;
  endtask

  task automatic drive_master(input int i, input bit on);
    m_addr[i*AW +: AW]   = op_addr[i];
    m_data_w[i*DW +: DW] = op_data[i];
    m_addr_strobe[i]     = on;
    m_read_trg[i]        = on & op_rd[i];
    m_write_trg[i]       = on & (!op_rd[i] | op_both[i]);
  endtask

  // All masters in mask request together; each drops on its own acknowledge.
  task automatic run_burst(input logic [NM-1:0] mask);
    logic [NM-1:0] pend;
    int guard, w, s;
    bit single, clr, mp;
    pend = mask; guard = 0; clr = 0; s = 0;
    single = ($countones(mask) == 1);
    for (int i = 0; i < NM; i++) if (mask[i]) begin drive_master(i, 1'b1); s = i; end
    while ((pend != '0 || clr) && guard < 300) begin
      @(negedge clock);
      guard++;
      chk("dtack_onehot", 32'($countones(m_dtack) <= 1), 1);
      if (clr) begin
        chk("clr_dtack", m_dtack, 0);
        chk("clr_timeout", m_timeout, 0);
        chk("clr_act", m_data_r_act, 0);
        clr = 0;
      end
      if (single && guard == 1) chk("strobe_edge0", addr_strobe, 0);
      if (single && guard == 2) begin
        chk("strobe_edge1", addr_strobe, 1);
        chk("read_trg", read_trg, op_rd[s]);
        chk("write_trg", write_trg, !op_rd[s]);
        chk("slave_addr", addr, op_addr[s]);
        if (!op_rd[s]) chk("slave_data_w", data_w, op_data[s]);
      end
      if (m_dtack != '0) begin
        w  = rr_pick(pend, model_last);
        mp = mapped(op_addr[w]);
        chk("owner", m_dtack, 1 << w);
        chk("grant", grant, w);
        chk("timeout", m_timeout, mp ? 0 : (1 << w));
        chk("data_act", m_data_r_act, (mp && op_rd[w]) ? (1 << w) : 0);
        chk("strobe_hold", addr_strobe, mp);
        if (single) chk("latency", guard - 1, mp ? sl_lat + 2 : T);
        if (mp) begin
          last_data = op_rd[w] ? ref_mem[op_addr[w][7:0]] : '0;
          if (!op_rd[w]) ref_mem[op_addr[w][7:0]] = op_data[w];
        end
        chk("data_r", m_data_r, last_data);
        drive_master(w, 1'b0);
        pend[w] = 1'b0;
        model_last = w;
        clr = 1;
      end
    end
    chk("burst_done", pend, 0);
    repeat (2) @(negedge clock);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [NM-1:0] mask;
    reset = 1'b0;
    m_addr = '0; m_data_w = '0;
    m_addr_strobe = '0; m_read_trg = '0; m_write_trg = '0;
    for (int i = 0; i < NM; i++) set_op(i, '0, '0, 1'b0, 1'b0);
    repeat (3) @(negedge clock);
    chk("rst_grant", grant, NM - 1);
    chk("rst_dtack", m_dtack, 0);
    chk("rst_act", m_data_r_act, 0);
    chk("rst_timeout", m_timeout, 0);
    chk("rst_data_r", m_data_r, 0);
    chk("rst_slave", {addr_strobe, read_trg, write_trg}, 0);
    chk("rst_addr", addr, 0);
    chk("rst_data_w", data_w, 0);
    reset = 1'b1;
    @(negedge clock);

    // single write, read back; then the 0xBEEF read by master 1
    sl_lat = 0; set_op(0, 16'h0040, 16'h1234, 1'b0, 1'b0); run_burst(3'b001);
    sl_lat = 1; set_op(1, 16'h0040, 16'h0000, 1'b1, 1'b0); run_burst(3'b010);
    sl_lat = 2; set_op(0, 16'h0044, 16'hBEEF, 1'b0, 1'b0); run_burst(3'b001);
    sl_lat = 0; set_op(1, 16'h0044, 16'h0000, 1'b1, 1'b1); run_burst(3'b010);

    // contention: masters 0 and 1 together, three rounds
    for (int r = 0; r < 3; r++) begin
      sl_lat = r;
      set_op(0, 16'h0050, 16'h1100 + 16'(r), 1'b0, 1'b0);
      set_op(1, 16'h0050, 16'h0000, 1'b1, 1'b0);
      run_burst(3'b011);
    end

    // reset in the middle of an access by master 0
    sl_lat = 6; set_op(0, 16'h0040, 16'h0000, 1'b1, 1'b0); drive_master(0, 1'b1);
    n = 0;
    do begin @(negedge clock); n++; end while (!addr_strobe && n < 10);
    chk("midrst_access", addr_strobe, 1);
    reset = 1'b0;
    @(negedge clock);
    chk("midrst_grant", grant, NM - 1);
    chk("midrst_m_out", {m_dtack, m_data_r_act, m_timeout}, 0);
    chk("midrst_data_r", m_data_r, 0);
    chk("midrst_slave", {addr_strobe, read_trg, write_trg}, 0);
    chk("midrst_addr", {addr, data_w}, 0);
    reset = 1'b1; drive_master(0, 1'b0);
    model_last = NM - 1; last_data = '0; sl_lat = 0;
    repeat (2) @(negedge clock);
    set_op(0, 16'h0046, 16'h0A0A, 1'b0, 1'b0);
    set_op(1, 16'h0047, 16'h0B0B, 1'b0, 1'b0);
    run_burst(3'b011);

    // unmapped address times out
    set_op(2, 16'hFFF0, 16'h0000, 1'b1, 1'b0); run_burst(3'b100);

    // early abort: master 0 leaves before the slave acks
    sl_lat = 10; set_op(0, 16'h0041, 16'h0000, 1'b1, 1'b0); drive_master(0, 1'b1);
    n = 0;
    do begin @(negedge clock); n++; end while (!addr_strobe && n < 10);
    chk("abort_access", addr_strobe, 1);
    @(negedge clock);
    drive_master(0, 1'b0);
    @(negedge clock);
    chk("abort_no_dtack", m_dtack, 0);
    chk("abort_slave_drop", {addr_strobe, read_trg, write_trg}, 0);
    dtack_force = 1'b1;
    set_op(1, 16'h0042, 16'h5A5A, 1'b0, 1'b0); drive_master(1, 1'b1);
    repeat (4) begin
      @(negedge clock);
      chk("release_wait_dtack", m_dtack, 0);
      chk("release_wait_strobe", addr_strobe, 0);
    end
    dtack_force = 1'b0; sl_lat = 0; model_last = 0;
    @(negedge clock);
    run_burst(3'b010);

    // randomized bursts against the model
    for (int r = 0; r < 30; r++) begin
      mask = NM'($urandom_range(1, (1 << NM) - 1));
      sl_lat = $urandom_range(0, 3);
      for (int i = 0; i < NM; i++) begin
        bit rd;
        rd = 1'($urandom_range(0, 1));
        set_op(i, ($urandom_range(0, 7) == 0) ? 16'hFFF0 : 16'h0040 + 16'($urandom_range(0, 7)),
               16'($urandom), rd, rd & ($urandom_range(0, 3) == 0));
      end
      run_burst(mask);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/flex_arbiter.md
# flex_arbiter

Round-robin arbiter that shares one flex primary bus (addr/data_w/read_trg/write_trg/addr_strobe → data_r/data_r_act/dtack) among `nr_masters` requesters. It sits between bus masters (SCU slave interface, local sequencers) and the flex register banks (`flex_out` and similar), which see it as a single master. It serialises accesses, holds each transfer until the owning master releases it, and aborts accesses to unmapped addresses with a timeout acknowledge.

## Interface
- `addr_bus_width`, `` `BB_ADDR_BUS_WIDTH ``: address width.
- `data_bus_width`, `` `BB_DATA_BUS_WIDTH ``: data width.
- `nr_masters`, 2: number of requesters, 2..8.
- `timeout_cycles`, 255: cycles to wait for slave dtack before abort, 2..65535.
- `clock`, in, 1: single clock.
- `reset`, in, 1: reset, synchronous, active-low (0 = reset).
- `m_addr`, in, `nr_masters*addr_bus_width`: master addresses, master i at slice i.
- `m_data_w`, in, `nr_masters*data_bus_width`: master write data.
- `m_addr_strobe`, `m_read_trg`, `m_write_trg`, in, `nr_masters`: per-master bus controls.
- `m_dtack`, out, `nr_masters`: per-master acknowledge.
- `m_data_r_act`, out, `nr_masters`: per-master read-data-valid.
- `m_timeout`, out, `nr_masters`: set together with `m_dtack` when the access was aborted.
- `m_data_r`, out, `data_bus_width`: read data, shared by all masters, valid for the master whose `m_dtack` is high.
- `addr`, `data_w`, `addr_strobe`, `read_trg`, `write_trg`, out: slave-side bus.
- `data_r`, `data_r_act`, `dtack`, in: slave-side returns, OR-combined across slaves outside this block.
- `grant`, out, `$clog2(nr_masters)` (min 1): index of the current or last owner.

## Operation
- Request from master i: `m_addr_strobe[i] & (m_read_trg[i] | m_write_trg[i])`. If both triggers are set, read wins.
- FSM states:
  - **IDLE**: slave controls low. If any request is present, pick the winner round-robin, starting at `grant+1` and wrapping modulo `nr_masters`. Latch addr, data_w and read/write type into the slave-side registers, update `grant`, clear the timeout counter, go to **ACCESS**.
  - **ACCESS**: drive `addr_strobe=1` and the latched trigger. If `dtack`=1, register `m_data_r<=data_r`, `m_data_r_act[g]<=data_r_act`, `m_dtack[g]<=1`, go to **HOLD**. Else, if the counter equals `timeout_cycles-1`, set `m_dtack[g]`, `m_timeout[g]`, drop the slave trigger and strobe, go to **HOLD**. Else increment the counter.
  - **HOLD**: keep the master outputs. When the granted request deasserts, clear `m_dtack[g]`, `m_data_r_act[g]` and `m_timeout[g]`, drop the slave strobe and trigger, go to **RELEASE**.
  - **RELEASE**: wait for `dtack`=0, then go to **IDLE**. There is no timeout in this state.
- All outputs are registered. Only the granted master ever sees `m_dtack`. Non-granted requests wait without error.
- `m_data_r` holds its last value outside of transfers.
- A granted master dropping its request in ACCESS before `dtack`: drop the slave controls, go to RELEASE, and give that master no `m_dtack`.
- The counter width is `$clog2(timeout_cycles+1)` and it saturates at `timeout_cycles-1`.

## Timing
- Reset (`reset`=0 at a clock edge): state IDLE. All slave-side outputs and `addr`/`data_w` are 0. `m_dtack`, `m_data_r_act`, `m_timeout` and `m_data_r` are 0. `grant` is `nr_masters-1`, so master 0 wins first.
- Reset asserted mid-transfer clears everything at the next edge. The slave sees its trigger drop and returns to its own idle.
- Request sampled at edge 0: slave strobe and trigger high after edge 1.
- Slave `dtack` sampled at edge n: `m_dtack[g]` high after edge n. Minimum master-visible latency is 2 cycles when the slave acks in the same cycle it sees the trigger.
- Timeout: `m_dtack` rises `timeout_cycles` cycles after entering ACCESS.
- Back-to-back accesses need at least 1 IDLE cycle between transfers.
- Simultaneous requests: resolved only by the round-robin pointer. A request arriving during HOLD/RELEASE is served at the next IDLE.

## Structure
- Shared `flex_pkg`: FSM state enum (IDLE, ACCESS, HOLD, RELEASE) and the round-robin helper function (next index with wrap).
- Sub-module `flex_rr_select`: combinational round-robin pick from a request vector and the last grant, outputting index and valid. Reusable by later flex bus blocks.

## Test plan
- Single write: master 0 writes 0x1234 to a `flex_out` at base 0x0040. Slave `write_trg` is high after 1 cycle, `m_dtack[0]` follows the slave ack, and the register reads back 0x1234.
- Contention: masters 0 and 1 request in the same cycle, three times each. Grants alternate 0,1,0,1,0,1, and there is never overlap of `m_dtack`.
- Read: master 1 reads a register holding 0xBEEF. `m_data_r`=0xBEEF and `m_data_r_act[1]`=1 while `m_dtack[1]`=1.
- Unmapped address 0xFFF0 with `timeout_cycles`=8: `m_dtack` and `m_timeout` rise 8 cycles after ACCESS entry and clear when the master drops its trigger.
- Reset mid-ACCESS: all outputs are 0 on the next edge. After reset release, master 0 wins first.
- Early abort: master drops its trigger before the slave `dtack`. No `m_dtack` is generated, and the FSM returns to IDLE once the slave `dtack` is 0.
